// File: rtl/demux_pkg.sv
// Shared types and sizes for the 1:16 serial-to-parallel demultiplexer.
package demux_pkg;

  localparam int unsigned DEMUX_W = 16;
  localparam int unsigned SEL_W   = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PARITY  = 2'd1,
    HOLD    = 2'd2
  } demux_state_t;

endpackage

// File: rtl/bit_demux_1x16.sv
// Combinational 1-to-16 decoder: one-hot write enable for the selected bit.
module bit_demux_1x16
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic [DEMUX_W-1:0] we
);

  // Raise exactly one enable bit at index sel while the strobe is high.
  always_comb begin
    we = '0;
    if (en) we[sel] = 1'b1;
  end

endmodule

// File: rtl/demux_1x16_deser.sv
// Serial-to-parallel 1:16 demultiplexer with a valid/ready output port.
// Bits are placed LSB first at index sel; a full word is held until taken.
// Optional feature: define DEMUX_PARITY_EN to append an even-parity bit to
// each frame and report the result on parity_err (tied low otherwise).
module demux_1x16_deser
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_W
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic             parity_err
);

  demux_state_t       state_q, state_d;
  logic [DEMUX_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]   sel_q;
  logic [DEMUX_W-1:0] we;
  logic               accept;
  logic               data_acc;
  logic               last_bit;

  assign accept   = in_valid && in_ready;
  assign data_acc = accept && (state_q == COLLECT);
  assign last_bit = data_acc && (sel_q == '1);

  bit_demux_1x16 u_dec (
    .sel (sel_q),
    .en  (data_acc),
    .we  (we)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
    if (flush) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: begin
`ifdef DEMUX_PARITY_EN
          if (last_bit) state_d = PARITY;
`else
          if (last_bit) state_d = HOLD;
`endif
        end
`ifdef DEMUX_PARITY_EN
        PARITY:  if (accept) state_d = HOLD;
`endif
        HOLD:    if (out_ready) state_d = COLLECT;
        default: state_d = COLLECT;
      endcase
    end
  end

  // Merge the incoming bit; the first bit of a frame clears the old word.
  always_comb begin
    data_d = (sel_q == '0) ? '0 : data_q;
    data_d = (data_d & ~we) | (we & {DEMUX_W{in_bit}});
  end

  // Data word and select counter.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      data_q <= '0;
      sel_q  <= '0;
    end else if (data_acc) begin
      data_q <= data_d;
      sel_q  <= sel_q + SEL_W'(1);
    end
  end

`ifdef DEMUX_PARITY_EN
  logic perr_q;

  // Even-parity result over the 16 data bits plus the parity bit.
  always_ff @(posedge clk) begin
    if (!rst_n || flush)                  perr_q <= 1'b0;
    else if (accept && state_q == PARITY) perr_q <= (^data_q) ^ in_bit;
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign out_data = data_q;
  assign sel      = sel_q;

endmodule

// File: tb/tb_demux_1x16_deser.sv
// Scoreboard bench for demux_1x16_deser: randomized serial stimulus, expected
// frames queued from a word-level model, checked by an independent monitor.
module tb_demux_1x16_deser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  sel;
  logic        parity_err;

  typedef struct packed {
    logic [15:0] d;
    logic        pe;
  } frame_t;

  frame_t      sb[$];
  int unsigned exp_sel = 0;
  int          errors = 0;
  int          checks = 0;

  demux_1x16_deser #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sel        (sel),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle a frame is presented it must match the queue head.
  initial begin : monitor
    logic hs_prev;
    hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (hs_prev) begin
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_ready", 32'(in_ready), 32'd1);
        hs_prev = 1'b0;
      end
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("out_data", 32'(out_data), 32'(sb[0].d));
          chk("parity_err", 32'(parity_err), 32'(sb[0].pe));
          chk("hold_in_ready", 32'(in_ready), 32'd0);
          if (out_ready) begin
            void'(sb.pop_front());
            hs_prev = 1'b1;
          end
        end
      end
    end
  end

  // Offer one bit until accepted, with random idle cycles of probability gap%.
  task automatic send_bit(input logic b, input int unsigned gap, input logic is_data);
    int unsigned tries;
    logic acc;
    tries = 0;
    do begin
      in_valid = ($urandom_range(99) >= gap);
      in_bit   = in_valid ? b : 1'($urandom);
      @(negedge clk);
      acc = in_valid && in_ready;
      chk("sel", 32'(sel), 32'(exp_sel));
      @(posedge clk); #1;
      tries++;
    end while (!acc && tries < 200);
    if (!acc) chk("accept_timeout", 32'(tries), 32'd0);
    if (is_data) exp_sel = (exp_sel + 1) % 16;
    in_valid = 1'b0;
  endtask

  // Send the first n bits of w without completing a frame.
  task automatic send_bits(input logic [15:0] w, input int unsigned n, input int unsigned gap);
    for (int unsigned i = 0; i < n; i++) send_bit(w[i], gap, 1'b1);
  endtask

  // Send a whole frame and queue its expected word and parity result.
  task automatic send_frame(input logic [15:0] w, input int unsigned gap, input logic pbit);
    frame_t f;
    f.d = w;
`ifdef DEMUX_PARITY_EN
    f.pe = (^w) ^ pbit;
`else
    f.pe = 1'b0;
`endif
    for (int unsigned i = 0; i < 15; i++) send_bit(w[i], gap, 1'b1);
`ifdef DEMUX_PARITY_EN
    send_bit(w[15], gap, 1'b1);
    chk("no_valid_before_parity", 32'(out_valid), 32'd0);
    sb.push_back(f);
    send_bit(pbit, gap, 1'b0);
`else
    sb.push_back(f);
    send_bit(w[15], gap, 1'b1);
`endif
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("sel_wrap", 32'(sel), 32'd0);
  endtask

  // Wait (bounded) until every queued frame has been consumed.
  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_perr"}, 32'(parity_err), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    exp_sel = 0;
    check_idle("reset");
    rst_n = 1'b1;
  endtask

  initial begin : stim
    logic [15:0] w;
    @(posedge clk);
    do_reset();

    out_ready = 1'b1;
    send_frame(16'hA5C3, 0, 1'b0);
    drain();
    for (int unsigned k = 0; k < 16; k++) begin
      w = 16'h0001 << k;
      send_frame(w, 0, ^w);
      drain();
    end

    // Backpressure with bits offered during HOLD and the handshake cycle.
    out_ready = 1'b0;
    send_frame(16'h1234, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom);
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sel", 32'(sel), 32'd0);
      @(posedge clk); #1;
    end
    in_bit    = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    w = 16'($urandom);
    send_frame(w, 0, ^w);
    drain();

    // Flush mid-frame; the bit offered with flush is dropped.
    send_bits(16'h00FF, 7, 0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_sel  = 0;
    check_idle("flush");
    send_frame(16'hFFFF, 0, 1'b0);
    drain();

    send_frame(16'h0F0F, 50, 1'b0);
    drain();

    send_frame(16'h0003, 0, 1'b0);
    drain();
    send_frame(16'h0001, 0, 1'b0);
    drain();

    // Reset mid-frame, then reset while a frame is held.
    send_bits(16'hBEEF, 9, 0);
    do_reset();
    out_ready = 1'b0;
    send_frame(16'hC0DE, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    out_ready = 1'b1;
    send_frame(16'h5A5A, 0, 1'b0);
    drain();

    for (int n = 0; n < 6; n++) begin
      w = 16'($urandom);
      send_frame(w, $urandom_range(70), 1'($urandom));
      drain();
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin : watchdog
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
